// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter with ACK and timeout status
// Define PS2_HOST_TX_FILTER_EN to pass the device clock through a 4-sample glitch filter.
module ps2_host_tx #(
   parameter int INHIBIT_CYCLES = 2500,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk_vga,
   input  logic       reset,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic       timeout_err
);
   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_START,
      S_SHIFT,
      S_ACK,
      S_WAIT_IDLE
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    idx_q, idx_d;
   logic [8:0]    frame_q, frame_d;
   logic          ack_flag_q, ack_flag_d;
   logic [1:0]    clk_sync_q, data_sync_q;
   logic          clk_prev_q;
   logic          clk_line;
   logic          fall;
   logic          cur_bit;

   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         clk_sync_q  <= 2'b11;
         data_sync_q <= 2'b11;
      end else begin
         clk_sync_q  <= {clk_sync_q[0], ps2_clk_in};
         data_sync_q <= {data_sync_q[0], ps2_data_in};
      end
   end

`ifdef PS2_HOST_TX_FILTER_EN
   // Window is the three previous samples plus the current one, so a change lands 4 cycles late.
   logic [2:0] hist_q;
   logic       filt_q;

   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         hist_q <= 3'b111;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[1:0], clk_sync_q[1]};
         if ({hist_q, clk_sync_q[1]} == 4'hF) begin
            filt_q <= 1'b1;
         end else if ({hist_q, clk_sync_q[1]} == 4'h0) begin
            filt_q <= 1'b0;
         end
      end
   end

   assign clk_line = filt_q;
`else
   assign clk_line = clk_sync_q[1];
`endif

   assign fall     = clk_prev_q & ~clk_line;
   assign cur_bit  = (idx_q == 4'd0) ? 1'b0 : frame_q[idx_q - 4'd1];
   assign busy     = (state_q != S_IDLE);
   assign tx_ready = (state_q == S_IDLE);

   always_ff @(posedge clk_vga or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         frame_q    <= '0;
         ack_flag_q <= 1'b0;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         frame_q    <= frame_d;
         ack_flag_q <= ack_flag_d;
         clk_prev_q <= clk_line;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      frame_d     = frame_q;
      ack_flag_d  = ack_flag_q;
      ps2_clk_oe  = 1'b0;
      ps2_data_oe = 1'b0;
      done        = 1'b0;
      ack_err     = 1'b0;
      timeout_err = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tx_valid) begin
               frame_d    = {~^tx_data, tx_data};
               cnt_d      = '0;
               ack_flag_d = 1'b0;
               state_d    = S_INHIBIT;
            end
         end
         S_INHIBIT: begin
            ps2_clk_oe = 1'b1;
            if (cnt_q == INH_LAST) begin
               cnt_d   = '0;
               state_d = S_START;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_START: begin
            ps2_clk_oe  = 1'b1;
            ps2_data_oe = 1'b1;
            idx_d       = '0;
            cnt_d       = '0;
            state_d     = S_SHIFT;
         end
         S_SHIFT: begin
            // Index 0 is the start bit, 1..8 the data LSB first, 9 the parity bit.
            ps2_data_oe = ~cur_bit;
            if (fall) begin
               if (idx_q == 4'd9) begin
                  state_d = S_ACK;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         S_ACK: begin
            if (fall) begin
               ack_flag_d = data_sync_q[1];
               state_d    = S_WAIT_IDLE;
            end
         end
         S_WAIT_IDLE: begin
            if (clk_line && data_sync_q[1]) begin
               done    = 1'b1;
               ack_err = ack_flag_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Device-paced states share one inter-edge watchdog; an expiry overrides any ACK outcome.
      if (state_q inside {S_SHIFT, S_ACK, S_WAIT_IDLE}) begin
         cnt_d = fall ? '0 : cnt_q + CNT_ONE;
         if (cnt_q >= TO_LAST) begin
            state_d     = S_IDLE;
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            done        = 1'b1;
            ack_err     = 1'b0;
            timeout_err = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;
   localparam int INH = 40;
   localparam int TO  = 300;
   localparam int H   = 12;

   logic       clk_vga = 1'b0;
   logic       reset;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       ps2_clk_in, ps2_data_in;
   logic       ps2_clk_oe, ps2_data_oe;
   logic       busy, done, ack_err, timeout_err;
   logic       dev_clk, dev_data;

   int total = 0;
   int bad = 0;
   int done_total = 0;

   ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
      .clk_vga(clk_vga), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
      .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy), .done(done),
      .ack_err(ack_err), .timeout_err(timeout_err)
   );

   always #20 clk_vga = ~clk_vga;

   // Open-drain pads: either side may pull low.
   assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
   assign ps2_data_in = dev_data & ~ps2_data_oe;

   always @(negedge clk_vga) if (done === 1'b1) done_total++;

   // Wire image of a frame: [0]=start 0, [1..8]=data LSB first, [9]=odd parity, [10]=stop 1.
   function automatic logic [10:0] frame_of(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) if (b[i]) ones++;
      return {1'b1, ((ones % 2) == 0) ? 1'b1 : 1'b0, b, 1'b0};
   endfunction

   task automatic start_frame(input logic [7:0] b, output int inh, output int st);
      inh = 0;
      st  = 0;
      @(negedge clk_vga);
      tx_data  = b;
      tx_valid = 1'b1;
      @(posedge clk_vga);
      #1;
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      for (int i = 0; i < INH + 20; i++) begin
         @(negedge clk_vga);
         if (ps2_clk_oe && !ps2_data_oe) inh++;
         else if (ps2_clk_oe && ps2_data_oe) st++;
         else break;
      end
   endtask

   task automatic device_clocks(input int nedges, input bit ack, input int glitch_k,
                                output logic [10:0] samp);
      samp    = '0;
      samp[0] = ps2_data_in;
      for (int k = 1; k <= nedges; k++) begin
         repeat (H) @(negedge clk_vga);
         dev_clk = 1'b0;
         repeat (H) @(negedge clk_vga);
         if (k <= 10) samp[k] = ps2_data_in;
         dev_clk = 1'b1;
         if (k == 10 && ack) dev_data = 1'b0;
         if (k == 11) dev_data = 1'b1;
         if (k == glitch_k) begin
            repeat (4) @(negedge clk_vga);
            dev_clk = 1'b0;
            repeat (2) @(negedge clk_vga);
            dev_clk = 1'b1;
         end
      end
   endtask

   task automatic wait_done(output int cyc, output bit seen, output bit ae, output bit te,
                            output bit oe_any);
      seen = 1'b0; ae = 1'b0; te = 1'b0; oe_any = 1'b0;
      for (cyc = 1; cyc <= TO + 100; cyc++) begin
         @(negedge clk_vga);
         if (done === 1'b1) begin
            seen   = 1'b1;
            ae     = ack_err;
            te     = timeout_err;
            oe_any = ps2_clk_oe | ps2_data_oe;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk_vga);
      total++;
      if ({tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err} !== 7'b1000000) begin
         bad++;
         $display("FAIL reset_hold: got %b want 1000000",
                  {tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, ack_err, timeout_err});
      end
      reset = 1'b0;
      repeat (3) @(negedge clk_vga);
      total++;
      if ({tx_ready, ps2_clk_oe, ps2_data_oe, busy, done} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_release: got %b want 10000",
                  {tx_ready, ps2_clk_oe, ps2_data_oe, busy, done});
      end
   endtask

   task automatic test_send_ed();
      int inh, st, cyc;
      bit seen, ae, te, oe_any;
      logic [10:0] s;
      start_frame(8'hED, inh, st);
      total++;
      if (inh != INH) begin bad++; $display("FAIL ed_inhibit_len: got %0d want %0d", inh, INH); end
      total++;
      if (st != 1) begin bad++; $display("FAIL ed_start_len: got %0d want 1", st); end
      device_clocks(11, 1'b1, 0, s);
      total++;
      if (s !== frame_of(8'hED)) begin
         bad++; $display("FAIL ed_frame: got %b want %b", s, frame_of(8'hED));
      end
      wait_done(cyc, seen, ae, te, oe_any);
      total++;
      if ({seen, ae, te} !== 3'b100) begin bad++; $display("FAIL ed_done: got %b want 100", {seen, ae, te}); end
      @(negedge clk_vga);
      total++;
      if ({tx_ready, done} !== 2'b10) begin bad++; $display("FAIL ed_ready_after: got %b want 10", {tx_ready, done}); end
   endtask

   task automatic test_send_00_noack();
      int inh, st, cyc;
      bit seen, ae, te, oe_any;
      logic [10:0] s;
      start_frame(8'h00, inh, st);
      device_clocks(11, 1'b0, 0, s);
      total++;
      if (s !== frame_of(8'h00)) begin
         bad++; $display("FAIL zero_frame: got %b want %b", s, frame_of(8'h00));
      end
      wait_done(cyc, seen, ae, te, oe_any);
      total++;
      if ({seen, ae, te} !== 3'b110) begin bad++; $display("FAIL zero_ack_err: got %b want 110", {seen, ae, te}); end
      @(negedge clk_vga);
      total++;
      if ({tx_ready, ack_err} !== 2'b10) begin bad++; $display("FAIL zero_pulse_width: got %b want 10", {tx_ready, ack_err}); end
   endtask

   task automatic test_timeout();
      int inh, st, cyc;
      bit seen, ae, te, oe_any;
      logic [10:0] s;
      logic [10:0] exp;
      exp = frame_of(8'hA7);
      start_frame(8'hA7, inh, st);
      device_clocks(5, 1'b1, 0, s);
      total++;
      if (s[5:0] !== exp[5:0]) begin bad++; $display("FAIL to_partial: got %b want %b", s[5:0], exp[5:0]); end
      wait_done(cyc, seen, ae, te, oe_any);
      total++;
      if ({seen, ae, te, oe_any} !== 4'b1010) begin
         bad++; $display("FAIL to_pulse: got %b want 1010", {seen, ae, te, oe_any});
      end
      total++;
      if (cyc + H < TO || cyc + H > TO + 8) begin
         bad++; $display("FAIL to_latency: got %0d want %0d..%0d", cyc + H, TO, TO + 8);
      end
      @(negedge clk_vga);
      total++;
      if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b1000) begin
         bad++; $display("FAIL to_idle: got %b want 1000", {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
      end
   endtask

   task automatic test_ignore_busy();
      int inh, st, cyc, base, oe_seen;
      bit seen, ae, te, oe_any;
      logic rdy;
      logic [10:0] s;
      base = done_total;
      rdy = 1'b1;
      start_frame(8'hFF, inh, st);
      fork
         device_clocks(11, 1'b1, 0, s);
         begin
            repeat (5 * H) @(negedge clk_vga);
            tx_data  = 8'h55;
            tx_valid = 1'b1;
            rdy      = tx_ready;
            @(negedge clk_vga);
            tx_valid = 1'b0;
         end
      join
      total++;
      if (rdy !== 1'b0) begin bad++; $display("FAIL busy_ready: got %b want 0", rdy); end
      total++;
      if (s !== frame_of(8'hFF)) begin bad++; $display("FAIL busy_frame: got %b want %b", s, frame_of(8'hFF)); end
      wait_done(cyc, seen, ae, te, oe_any);
      oe_seen = 0;
      repeat (INH + 40) begin
         @(negedge clk_vga);
         if (ps2_clk_oe || busy) oe_seen++;
      end
      total++;
      if (oe_seen != 0 || done_total - base != 1) begin
         bad++; $display("FAIL busy_one_frame: got oe=%0d dones=%0d want 0 and 1", oe_seen, done_total - base);
      end
   endtask

   task automatic test_reset_mid();
      int inh, st, cyc, base;
      bit seen, ae, te, oe_any;
      logic [10:0] s;
      base = done_total;
      start_frame(8'hAA, inh, st);
      device_clocks(4, 1'b1, 0, s);
      repeat (H) @(negedge clk_vga);
      dev_clk = 1'b0;
      repeat (6) @(negedge clk_vga);
      total++;
      if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL rst_pre_bit4: got %b want 1", ps2_data_oe); end
      #5 reset = 1'b1;
      #1;
      total++;
      if ({ps2_clk_oe, ps2_data_oe, busy} !== 3'b000) begin
         bad++; $display("FAIL rst_release: got %b want 000", {ps2_clk_oe, ps2_data_oe, busy});
      end
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      repeat (3) @(negedge clk_vga);
      reset = 1'b0;
      repeat (3) @(negedge clk_vga);
      total++;
      if (done_total != base || tx_ready !== 1'b1) begin
         bad++; $display("FAIL rst_no_done: got dones=%0d ready=%b want 0 and 1", done_total - base, tx_ready);
      end
      start_frame(8'hF4, inh, st);
      device_clocks(11, 1'b1, 0, s);
      total++;
      if (s !== frame_of(8'hF4)) begin bad++; $display("FAIL rst_f4_frame: got %b want %b", s, frame_of(8'hF4)); end
      wait_done(cyc, seen, ae, te, oe_any);
      total++;
      if ({seen, ae, te} !== 3'b100) begin bad++; $display("FAIL rst_f4_done: got %b want 100", {seen, ae, te}); end
   endtask

   task automatic test_glitch();
      int inh, st, cyc;
      bit seen, ae, te, oe_any, exp_ae;
      logic [10:0] s, frame, exp;
      frame = frame_of(8'hED);
      exp   = frame;
`ifdef PS2_HOST_TX_FILTER_EN
      exp_ae = 1'b0;
`else
      // The glitch counts as an extra edge: later bits come one early and ACK is sampled too soon.
      for (int j = 4; j <= 10; j++) exp[j] = frame[(j + 1 > 10) ? 10 : j + 1];
      exp_ae = 1'b1;
`endif
      start_frame(8'hED, inh, st);
      device_clocks(11, 1'b1, 3, s);
      total++;
      if (s !== exp) begin bad++; $display("FAIL glitch_frame: got %b want %b", s, exp); end
      wait_done(cyc, seen, ae, te, oe_any);
      total++;
      if ({seen, ae, te} !== {1'b1, exp_ae, 1'b0}) begin
         bad++; $display("FAIL glitch_done: got %b want %b", {seen, ae, te}, {1'b1, exp_ae, 1'b0});
      end
   endtask

   task automatic test_random();
      int inh, st, cyc;
      bit seen, ae, te, oe_any, ack;
      logic [7:0] b;
      logic [10:0] s;
      for (int n = 0; n < 5; n++) begin
         b   = 8'($urandom);
         ack = 1'($urandom_range(0, 1));
         start_frame(b, inh, st);
         device_clocks(11, ack, 0, s);
         total++;
         if (s !== frame_of(b)) begin bad++; $display("FAIL rand_frame %02h: got %b want %b", b, s, frame_of(b)); end
         wait_done(cyc, seen, ae, te, oe_any);
         total++;
         if ({seen, ae, te} !== {1'b1, ~ack, 1'b0}) begin
            bad++; $display("FAIL rand_done %02h: got %b want %b", b, {seen, ae, te}, {1'b1, ~ack, 1'b0});
         end
      end
   endtask

   initial begin
      reset    = 1'b1;
      tx_valid = 1'b0;
      tx_data  = 8'h00;
      dev_clk  = 1'b1;
      dev_data = 1'b1;
      test_reset();
      test_send_ed();
      test_send_00_noack();
      test_timeout();
      test_ignore_busy();
      test_reset_mid();
      test_glitch();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the other direction of the existing PS/2 keyboard receiver.
- Sends command bytes to the keyboard, e.g. 0xED + LED mask, or 0xFF reset.
- Drives the open-drain ps2_clk/ps2_data pads through output-enables at top level.
- Reports ACK/timeout status to the requester; runs in the clk_vga (25 MHz) domain.

Parameters:
- INHIBIT_CYCLES, 2500: clock-inhibit duration in clk_vga cycles (100 us at 25 MHz).
- TIMEOUT_CYCLES, 50000: max clk_vga cycles between consecutive device falling edges (2 ms) before abort.

Ports:
- clk_vga  in  1  system clock, 25 MHz
- reset  in  1  asynchronous, active-high
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid & tx_ready
- tx_ready  out  1  high only in IDLE
- ps2_clk_in  in  1  raw pad level of PS/2 clock
- ps2_data_in  in  1  raw pad level of PS/2 data
- ps2_clk_oe  out  1  1 = pull clock pad low
- ps2_data_oe  out  1  1 = pull data pad low
- busy  out  1  high in every state except IDLE; keyboard receiver ignores line activity while high
- done  out  1  one-cycle pulse at end of transfer
- ack_err  out  1  one-cycle pulse with done when device did not ACK
- timeout_err  out  1  one-cycle pulse with done on timeout abort

Behaviour:
- Reset: tx_ready=1; ps2_clk_oe=0, ps2_data_oe=0, busy=0, done=0, ack_err=0, timeout_err=0; state IDLE; synchronisers reset to 1.
- Reset asserted mid-transfer releases both lines immediately (async); no done pulse.
- Inputs: 2-flop synchroniser per line. Falling edge = previous synced clock 1 and current 0; one-cycle strobe.
- Latch: on acceptance, register {odd_parity, tx_data}. odd_parity = ~^tx_data. tx_data is don't-care afterwards.
- IDLE:
  - oe both 0.
  - On accept -> INHIBIT, counter cleared.
- INHIBIT:
  - clk_oe=1, data_oe=0.
  - After INHIBIT_CYCLES cycles -> START.
- START (exactly 1 cycle):
  - clk_oe=1, data_oe=1 (start bit 0).
  - -> SHIFT with bit index 0; timeout counter cleared.
- SHIFT:
  - clk_oe=0; data_oe holds the current bit (start bit first).
  - Each falling edge loads the next bit onto data: d0..d7 on edges 1-8, parity on edge 9. data_oe = ~bit.
  - Edge 10 releases data (stop bit 1) -> ACK.
- ACK:
  - oe both 0.
  - Next falling edge samples synced data: 0 = ACK OK, 1 = ack_err.
  - -> WAIT_IDLE.
- WAIT_IDLE:
  - Wait until synced clock and data are both 1, then pulse done (plus ack_err if flagged) -> IDLE.
  - tx_ready returns the cycle after done.
- Timeout:
  - In SHIFT, ACK and WAIT_IDLE, the counter increments every cycle and clears on each falling edge.
  - On reaching TIMEOUT_CYCLES: release both lines, pulse done + timeout_err -> IDLE.
  - If both conditions occur, timeout has priority over the ACK result.
- A new tx_valid while busy is ignored: tx_ready=0, no queueing.
- Edges seen in IDLE or INHIBIT are ignored.
- Minimum transfer = INHIBIT_CYCLES + 1 + 11 device clocks + idle wait.

Optional Feature:
- Macro PS2_HOST_TX_FILTER_EN.
- Defined:
  - Synced clock passes through a 4-sample majority-stable filter; the output changes only after 4 consecutive equal samples.
  - Adds 4 cycles of edge latency; rejects glitches shorter than 4 cycles.
- Undefined: raw 2-flop synchronised clock is used directly.
- Data sampling and timing rules are otherwise identical.

Test Plan:
- Send 0xED, device model 12.5 kHz with ACK:
  - clk_oe low for exactly 2500 cycles, then 1-cycle start.
  - Device samples 0,1,0,1,1,0,1,1,1, parity 1, stop 1.
  - done=1, ack_err=0; tx_ready high after.
- Send 0x00:
  - Parity bit 1; all data bits drive data_oe=1.
  - With device giving no ACK (data high on edge 11): done+ack_err pulse.
- Device stops clocking after edge 5:
  - After 50000 cycles, oe both 0, done+timeout_err pulse, state IDLE, tx_ready=1.
- tx_valid pulsed during an active transfer with 0x55:
  - Ignored; exactly one frame (first byte 0xFF) observed on the wire.
- Reset asserted at bit 4:
  - Both oe drop to 0 in the same cycle, no done.
  - After release, a new 0xF4 send completes normally.
- With PS2_HOST_TX_FILTER_EN: 2-cycle low glitch on clock during SHIFT:
  - No bit advance; frame for 0xED is still correct.
  - Without the macro, a test documents that the glitch advances the bit.
